// File: rtl/seg_scan_if.sv
// Display-side bus of seg_scan: digit/dp inputs from the counters, multiplexed
// segment, digit-select and frame-marker outputs toward the board pins.
interface seg_scan_if;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_done;

  modport master (
    output en, bcd_in, dp_in,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  en, bcd_in, dp_in,
    output seg, dp, dig_sel, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame shadow digits
// and per-slot blanking. Define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan #(
  parameter int unsigned SCAN_DIV     = 24000,
  parameter int unsigned BLANK_CYC    = 240,
  parameter int unsigned COMMON_ANODE = 0
) (
  input logic       clk,
  input logic       res,
  seg_scan_if.slave bus
);

  localparam logic [24:0] LAST_CNT  = 25'(SCAN_DIV - 1);
  localparam logic [24:0] BLANK_LIM = 25'(BLANK_CYC);
  localparam logic        POL       = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_DIG0 = 2'd0,
    S_DIG1 = 2'd1,
    S_DIG2 = 2'd2,
    S_DIG3 = 2'd3
  } scan_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [24:0] r_con_t;
  logic [24:0] w_con_nxt;
  logic [15:0] r_shadow_bcd;
  logic [3:0]  r_shadow_dp;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [3:0]  r_dig_sel;
  logic        r_frame_done;

  logic        w_slot_end;
  logic        w_frame_end;
  logic        w_frame_nxt;
  logic        w_visible;
  logic [3:0]  w_digit;
  logic        w_dp_cur;
  logic [3:0]  w_onehot;
  logic        w_lz_cur;
  logic [3:0]  w_lz;
  logic [6:0]  w_seg_act;
  logic        w_dp_act;
  logic [3:0]  w_dig_act;

  assign w_slot_end  = (r_con_t == LAST_CNT);
  assign w_frame_end = bus.en && w_slot_end && (r_state == S_DIG3);

  always_comb begin
    w_state_nxt = r_state;
    w_con_nxt   = r_con_t;
    if (!bus.en) begin
      w_state_nxt = S_DIG0;
      w_con_nxt   = 25'd0;
    end else if (w_slot_end) begin
      w_con_nxt = 25'd0;
      case (r_state)
        S_DIG0:  w_state_nxt = S_DIG1;
        S_DIG1:  w_state_nxt = S_DIG2;
        S_DIG2:  w_state_nxt = S_DIG3;
        S_DIG3:  w_state_nxt = S_DIG0;
        default: w_state_nxt = S_DIG0;
      endcase
    end else begin
      w_con_nxt = r_con_t + 25'd1;
    end
  end

  // frame_done is registered from the next state so it is high during the boundary cycle itself
  assign w_frame_nxt = bus.en && (w_con_nxt == LAST_CNT) && (w_state_nxt == S_DIG3);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state      <= S_DIG0;
      r_con_t      <= 25'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_con_t      <= w_con_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end

  // Transparent while disabled, otherwise only updated at the frame boundary
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_shadow_bcd <= 16'h0000;
      r_shadow_dp  <= 4'b0000;
    end else if (!bus.en || w_frame_end) begin
      r_shadow_bcd <= bus.bcd_in;
      r_shadow_dp  <= bus.dp_in;
    end else begin
      r_shadow_bcd <= r_shadow_bcd;
      r_shadow_dp  <= r_shadow_dp;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic w_lz3;
  logic w_lz2;
  logic w_lz1;
  assign w_lz3 = (r_shadow_bcd[15:12] == 4'd0);
  assign w_lz2 = w_lz3 && (r_shadow_bcd[11:8] == 4'd0);
  assign w_lz1 = w_lz2 && (r_shadow_bcd[7:4] == 4'd0);
  assign w_lz  = {w_lz3, w_lz2, w_lz1, 1'b0};
`else
  assign w_lz  = 4'b0000;
`endif

  always_comb begin
    w_digit  = r_shadow_bcd[3:0];
    w_dp_cur = r_shadow_dp[0];
    w_onehot = 4'b0001;
    w_lz_cur = w_lz[0];
    case (r_state)
      S_DIG0: begin
        w_digit  = r_shadow_bcd[3:0];
        w_dp_cur = r_shadow_dp[0];
        w_onehot = 4'b0001;
        w_lz_cur = w_lz[0];
      end
      S_DIG1: begin
        w_digit  = r_shadow_bcd[7:4];
        w_dp_cur = r_shadow_dp[1];
        w_onehot = 4'b0010;
        w_lz_cur = w_lz[1];
      end
      S_DIG2: begin
        w_digit  = r_shadow_bcd[11:8];
        w_dp_cur = r_shadow_dp[2];
        w_onehot = 4'b0100;
        w_lz_cur = w_lz[2];
      end
      S_DIG3: begin
        w_digit  = r_shadow_bcd[15:12];
        w_dp_cur = r_shadow_dp[3];
        w_onehot = 4'b1000;
        w_lz_cur = w_lz[3];
      end
      default: begin
        w_digit  = 4'd0;
        w_dp_cur = 1'b0;
        w_onehot = 4'b0000;
        w_lz_cur = 1'b1;
      end
    endcase
  end

  assign w_visible = bus.en && (r_con_t >= BLANK_LIM);
  assign w_seg_act = (w_visible && !w_lz_cur) ? seg_decode(w_digit) : 7'h00;
  assign w_dp_act  = w_visible && w_dp_cur;
  assign w_dig_act = w_visible ? w_onehot : 4'b0000;

  // Polarity is applied here so every pin is a flop output
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_seg     <= {7{POL}};
      r_dp      <= POL;
      r_dig_sel <= {4{POL}};
    end else begin
      r_seg     <= w_seg_act ^ {7{POL}};
      r_dp      <= w_dp_act ^ POL;
      r_dig_sel <= w_dig_act ^ {4{POL}};
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig_sel    = r_dig_sel;
  assign bus.frame_done = r_frame_done;

endmodule
